// File: rtl/fft_power_pkg.sv
// Shared definitions for the FFT power pipeline: lane count, default widths,
// the lane power-word type and the frame accumulator state encoding.
package fft_power_pkg;

   localparam int unsigned LANES           = 4;
   localparam int unsigned DEF_DATA_WIDTH  = 53;
   localparam int unsigned DEF_INDEX_WIDTH = 11;
   localparam int unsigned DEF_ACC_WIDTH   = 64;

   typedef logic [DEF_DATA_WIDTH-1:0] power_word_t;

   typedef enum logic {
      IDLE,
      ACCUM
   } state_t;

endpackage

// File: rtl/sat_acc_lane.sv
// One lane of saturating frame accumulation. acc_next is the value the lane
// holds after this cycle, so the top can capture a frame total without delay.
module sat_acc_lane #(
   parameter int unsigned SUM_WIDTH = 54,
   parameter int unsigned ACC_WIDTH = 64
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 load,
   input  logic                 add,
   input  logic [SUM_WIDTH-1:0] beat_sum,
   output logic [ACC_WIDTH-1:0] acc_next
);

   logic [ACC_WIDTH-1:0] acc;
   logic [ACC_WIDTH:0]   sum_ext;
   logic [ACC_WIDTH:0]   total;

   // Carry out of the widened add means the lane overflowed; clamp to all-ones.
   always_comb begin
      sum_ext                = '0;
      sum_ext[SUM_WIDTH-1:0] = beat_sum;
      total                  = {1'b0, acc} + sum_ext;
      acc_next               = acc;
      if (load) begin
         acc_next = sum_ext[ACC_WIDTH-1:0];
      end else if (add) begin
         acc_next = total[ACC_WIDTH] ? '1 : total[ACC_WIDTH-1:0];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc <= '0;
      end else begin
         acc <= acc_next;
      end
   end

endmodule

// File: rtl/power_frame_accumulator.sv
// Sums per-lane power across one FFT frame and presents each completed frame
// through a one-deep valid/ready buffer; frames that cannot be buffered are dropped.
module power_frame_accumulator
   import fft_power_pkg::*;
#(
   parameter int unsigned DATA_WIDTH     = DEF_DATA_WIDTH,
   parameter int unsigned ACC_WIDTH      = DEF_ACC_WIDTH,
   parameter int unsigned INDEX_WIDTH    = DEF_INDEX_WIDTH,
   parameter int unsigned FRAME_LAST     = 1023,
   parameter int unsigned FRAME_ID_WIDTH = 16
) (
   input  logic                             clk,
   input  logic                             rst_n,
   input  logic                             in_valid,
   input  logic [LANES-1:0][DATA_WIDTH-1:0] in_col1,
   input  logic [LANES-1:0][DATA_WIDTH-1:0] in_col2,
   input  logic [INDEX_WIDTH-1:0]           in_index_col1,
   input  logic [INDEX_WIDTH-1:0]           in_index_col2,
   output logic                             out_valid,
   input  logic                             out_ready,
   output logic [LANES-1:0][ACC_WIDTH-1:0]  out_energy,
   output logic [FRAME_ID_WIDTH-1:0]        out_frame_id,
   output logic                             overrun,
   output logic                             sync_err
);

   localparam int unsigned SUM_WIDTH = DATA_WIDTH + 1;
   localparam logic [INDEX_WIDTH-1:0] LAST_INDEX = INDEX_WIDTH'(FRAME_LAST);
   localparam logic [INDEX_WIDTH-1:0] NEXT_AFTER_FIRST = INDEX_WIDTH'(1);

   state_t                          state, state_next;
   logic [INDEX_WIDTH-1:0]          expected, expected_next;
   logic [FRAME_ID_WIDTH-1:0]       frame_cnt;
   logic                            lane_load, lane_add, complete, sync_next, drain;
   logic [LANES-1:0][SUM_WIDTH-1:0] beat_sum;
   logic [LANES-1:0][ACC_WIDTH-1:0] acc_next;
   logic                            unused_index;

   assign unused_index = ^in_index_col2;
   assign drain        = out_valid && out_ready;

   for (genvar l = 0; l < LANES; l++) begin : g_lane
      assign beat_sum[l] = {1'b0, in_col1[l]} + {1'b0, in_col2[l]};

      sat_acc_lane #(
         .SUM_WIDTH (SUM_WIDTH),
         .ACC_WIDTH (ACC_WIDTH)
      ) u_lane (
         .clk      (clk),
         .rst_n    (rst_n),
         .load     (lane_load),
         .add      (lane_add),
         .beat_sum (beat_sum[l]),
         .acc_next (acc_next[l])
      );
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         expected <= '0;
      end else begin
         state    <= state_next;
         expected <= expected_next;
      end
   end

   // A single-beat frame (FRAME_LAST of 0) completes on the same beat that starts it.
   always_comb begin
      state_next    = state;
      expected_next = expected;
      lane_load     = 1'b0;
      lane_add      = 1'b0;
      complete      = 1'b0;
      sync_next     = 1'b0;
      if (in_valid) begin
         unique case (state)
            IDLE: begin
               if (in_index_col1 == '0) begin
                  lane_load     = 1'b1;
                  expected_next = NEXT_AFTER_FIRST;
                  if (FRAME_LAST == 0) begin
                     complete = 1'b1;
                  end else begin
                     state_next = ACCUM;
                  end
               end
            end
            ACCUM: begin
               if (in_index_col1 == expected) begin
                  lane_add = 1'b1;
                  if (expected == LAST_INDEX) begin
                     complete   = 1'b1;
                     state_next = IDLE;
                  end else begin
                     expected_next = expected + 1'b1;
                  end
               end else if (in_index_col1 == '0) begin
                  sync_next     = 1'b1;
                  lane_load     = 1'b1;
                  expected_next = NEXT_AFTER_FIRST;
               end else begin
                  sync_next  = 1'b1;
                  state_next = IDLE;
               end
            end
            default: state_next = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid    <= 1'b0;
         out_energy   <= '0;
         out_frame_id <= '0;
         frame_cnt    <= '0;
         overrun      <= 1'b0;
         sync_err     <= 1'b0;
      end else begin
         overrun  <= 1'b0;
         sync_err <= sync_next;
         if (complete) begin
            frame_cnt <= frame_cnt + 1'b1;
            if (!out_valid || drain) begin
               out_valid    <= 1'b1;
               out_energy   <= acc_next;
               out_frame_id <= frame_cnt;
            end else begin
               overrun <= 1'b1;
            end
         end else if (drain) begin
            out_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_power_frame_accumulator.sv
// Bench for power_frame_accumulator (FRAME_LAST=3, ACC_WIDTH=55): directed
// scenarios with literal expectations plus a randomized run against a model.
module tb_power_frame_accumulator;

   localparam int unsigned DW = 53;
   localparam int unsigned AW = 55;
   localparam int unsigned IW = 11;
   localparam int unsigned FL = 3;
   localparam int unsigned FW = 16;
   localparam longint unsigned SAT   = (64'd1 << AW) - 64'd1;
   localparam longint unsigned MAXIN = (64'd1 << DW) - 64'd1;

   logic                clk = 1'b0;
   logic                rst_n = 1'b0;
   logic                in_valid = 1'b0;
   logic [3:0][DW-1:0]  in_col1 = '0;
   logic [3:0][DW-1:0]  in_col2 = '0;
   logic [IW-1:0]       in_index_col1 = '0;
   logic [IW-1:0]       in_index_col2 = '0;
   logic                out_valid;
   logic                out_ready = 1'b0;
   logic [3:0][AW-1:0]  out_energy;
   logic [FW-1:0]       out_frame_id;
   logic                overrun;
   logic                sync_err;

   int n_cmp = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   power_frame_accumulator #(
      .DATA_WIDTH     (DW),
      .ACC_WIDTH      (AW),
      .INDEX_WIDTH    (IW),
      .FRAME_LAST     (FL),
      .FRAME_ID_WIDTH (FW)
   ) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .in_valid      (in_valid),
      .in_col1       (in_col1),
      .in_col2       (in_col2),
      .in_index_col1 (in_index_col1),
      .in_index_col2 (in_index_col2),
      .out_valid     (out_valid),
      .out_ready     (out_ready),
      .out_energy    (out_energy),
      .out_frame_id  (out_frame_id),
      .overrun       (overrun),
      .sync_err      (sync_err)
   );

   task automatic check(input string name, input longint unsigned act, input longint unsigned exp);
      n_cmp++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Reference: a frame is the running lane totals plus how many in-order beats
   // have been collected; the clamp is applied once when the frame is done.
   longint unsigned m_sum[4];
   longint unsigned m_energy[4];
   int              m_cnt;
   int unsigned     m_frames;
   int unsigned     m_id;
   bit              m_valid, m_overrun, m_sync, m_drain;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int l = 0; l < 4; l++) begin
            m_sum[l]    = 0;
            m_energy[l] = 0;
         end
         m_cnt = 0; m_frames = 0; m_id = 0;
         m_valid = 0; m_overrun = 0; m_sync = 0;
      end else begin
         m_drain   = m_valid && out_ready;
         m_overrun = 0;
         m_sync    = 0;
         if (in_valid) begin
            if (in_index_col1 == IW'(m_cnt)) begin
               for (int l = 0; l < 4; l++)
                  m_sum[l] += longint'(in_col1[l]) + longint'(in_col2[l]);
               m_cnt++;
            end else if (m_cnt != 0) begin
               m_sync = 1;
               m_cnt  = 0;
               for (int l = 0; l < 4; l++) m_sum[l] = 0;
               if (in_index_col1 == '0) begin
                  for (int l = 0; l < 4; l++)
                     m_sum[l] = longint'(in_col1[l]) + longint'(in_col2[l]);
                  m_cnt = 1;
               end
            end
         end
         if (m_cnt == FL + 1) begin
            if (!m_valid || m_drain) begin
               m_valid = 1;
               m_id    = m_frames;
               for (int l = 0; l < 4; l++) m_energy[l] = (m_sum[l] > SAT) ? SAT : m_sum[l];
            end else begin
               m_overrun = 1;
            end
            m_frames++;
            m_cnt = 0;
            for (int l = 0; l < 4; l++) m_sum[l] = 0;
         end else if (m_drain) begin
            m_valid = 0;
         end
      end
   end

   always @(posedge clk) begin
      #1;
      check("out_valid", longint'(out_valid), longint'(m_valid));
      check("out_frame_id", longint'(out_frame_id), longint'(FW'(m_id)));
      check("overrun", longint'(overrun), longint'(m_overrun));
      check("sync_err", longint'(sync_err), longint'(m_sync));
      for (int l = 0; l < 4; l++)
         check($sformatf("out_energy[%0d]", l), longint'(out_energy[l]), m_energy[l]);
   end

   task automatic beat(input int idx, input longint unsigned a, input longint unsigned b);
      @(negedge clk);
      in_valid      = 1'b1;
      in_index_col1 = IW'(idx);
      in_index_col2 = IW'(idx + 1);
      for (int l = 0; l < 4; l++) begin
         in_col1[l] = DW'(a);
         in_col2[l] = DW'(b);
      end
   endtask

   task automatic idle();
      @(negedge clk);
      in_valid = 1'b0;
   endtask

   task automatic frame(input longint unsigned a, input longint unsigned b);
      for (int i = 0; i <= FL; i++) beat(i, a, b);
   endtask

   task automatic accept();
      out_ready = 1'b1;
      idle();
      out_ready = 1'b0;
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
      $fatal(1, "watchdog");
   end

   int          nxt;
   int          idx;
   int unsigned sel;

   initial begin
      repeat (3) @(negedge clk);
      check("reset out_valid", longint'(out_valid), 0);
      check("reset out_energy[0]", longint'(out_energy[0]), 0);
      check("reset out_frame_id", longint'(out_frame_id), 0);
      rst_n = 1'b1;

      frame(10, 5);
      idle();
      check("clean valid", longint'(out_valid), 1);
      for (int l = 0; l < 4; l++) check("clean energy", longint'(out_energy[l]), 60);
      check("clean id", longint'(out_frame_id), 0);
      accept();
      check("clean drop", longint'(out_valid), 0);

      beat(0, 10, 5); idle(); idle();
      beat(1, 10, 5); idle(); idle();
      beat(2, 10, 5); beat(3, 10, 5);
      for (int c = 0; c < 5; c++) begin
         idle();
         check("stall valid", longint'(out_valid), 1);
         check("stall energy", longint'(out_energy[2]), 60);
         check("stall id", longint'(out_frame_id), 1);
      end
      accept();
      check("stall drop", longint'(out_valid), 0);

      frame(1, 2);
      frame(3, 4);
      idle();
      check("overrun pulse", longint'(overrun), 1);
      check("overrun id", longint'(out_frame_id), 2);
      check("overrun energy", longint'(out_energy[0]), 12);
      beat(0, 7, 1); beat(1, 7, 1); beat(2, 7, 1); beat(3, 7, 1);
      out_ready = 1'b1;
      idle();
      out_ready = 1'b0;
      check("drain overrun", longint'(overrun), 0);
      check("drain id", longint'(out_frame_id), 4);
      check("drain energy", longint'(out_energy[3]), 32);
      check("drain valid", longint'(out_valid), 1);
      accept();

      beat(0, 10, 5); beat(1, 10, 5); beat(3, 10, 5);
      idle();
      check("sync gap err", longint'(sync_err), 1);
      check("sync gap valid", longint'(out_valid), 0);
      beat(0, 100, 100); beat(1, 100, 100);
      beat(0, 10, 5);
      beat(1, 10, 5);
      check("sync restart err", longint'(sync_err), 1);
      beat(2, 10, 5); beat(3, 10, 5);
      idle();
      check("sync restart energy", longint'(out_energy[1]), 60);
      check("sync restart id", longint'(out_frame_id), 5);
      accept();

      frame(MAXIN, MAXIN);
      idle();
      check("sat energy", longint'(out_energy[0]), SAT);
      check("sat id", longint'(out_frame_id), 6);

      beat(0, 10, 5); beat(1, 10, 5); beat(2, 10, 5);
      @(negedge clk);
      in_valid = 1'b0;
      rst_n    = 1'b0;
      #1;
      check("rst valid", longint'(out_valid), 0);
      check("rst energy", longint'(out_energy[0]), 0);
      @(negedge clk);
      rst_n = 1'b1;
      frame(10, 5);
      idle();
      check("post-rst id", longint'(out_frame_id), 0);
      check("post-rst energy", longint'(out_energy[0]), 60);
      accept();

      nxt = 0;
      for (int c = 0; c < 3000; c++) begin
         @(negedge clk);
         if (c == 1500) begin
            rst_n    = 1'b0;
            in_valid = 1'b0;
            @(negedge clk);
            rst_n = 1'b1;
            nxt   = 0;
         end
         out_ready = ($urandom_range(0, 2) == 0);
         in_valid  = ($urandom_range(0, 3) != 0);
         if (in_valid) begin
            idx = ($urandom_range(0, 19) == 0) ? int'($urandom_range(0, 5)) : nxt;
            nxt = (idx >= int'(FL)) ? 0 : idx + 1;
            in_index_col1 = IW'(idx);
            in_index_col2 = IW'($urandom);
            for (int l = 0; l < 4; l++) begin
               sel = $urandom_range(0, 3);
               case (sel)
                  0:       in_col1[l] = DW'($urandom_range(0, 1000));
                  1:       in_col1[l] = DW'({$urandom, $urandom});
                  2:       in_col1[l] = DW'(MAXIN);
                  default: in_col1[l] = DW'({$urandom, $urandom} >> 4);
               endcase
               in_col2[l] = (idx <= 1) ? '0 : DW'({$urandom, $urandom} >> ($urandom_range(0, 1) * 40));
            end
         end
      end
      idle();
      idle();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
